ahb_sram_slave: RTL

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

---
 rtl/ahb_sram_slave.sv | 116 +++++++++++
 1 files changed

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave front-end for a single-port SRAM with a combinational read port.
// Define AHB_SRAM_WAIT_EN to insert one wait state before every valid data phase.
module ahb_sram_slave #(
    parameter int unsigned MEM_DEPTH  = 2048,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    // AHB-Lite slave
    input  logic                          hsel,
    input  logic [31:0]                   haddr,
    input  logic [1:0]                    htrans,
    input  logic                          hwrite,
    input  logic [2:0]                    hsize,
    input  logic [DATA_WIDTH-1:0]         hwdata,
    input  logic                          hready,
    output logic                          hreadyout,
    output logic                          hresp,
    output logic [DATA_WIDTH-1:0]         hrdata,
    // SRAM side
    output logic                          mem_write_en,
    output logic                          mem_read_en,
    output logic [DATA_WIDTH/8-1:0]       mem_mask,
    output logic [$clog2(MEM_DEPTH)-1:0]  mem_address,
    output logic [DATA_WIDTH-1:0]         mem_write_data,
    input  logic [DATA_WIDTH-1:0]         mem_read_data
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;

`ifdef AHB_SRAM_WAIT_EN
    localparam state_t VALID_ST = WAIT;
`else
    localparam state_t VALID_ST = DATA;
`endif

    state_t                 state_q, state_d;
    logic [AW+1:0]          addr_q;
    logic                   write_q;
    logic [1:0]             size_q;
    logic                   ready_q;
    logic                   resp_q;

    logic                   accept;
    logic                   capture;
    logic                   addr_err;
    logic                   xfer_err;
    logic                   data_ph;
    logic [DATA_WIDTH/8-1:0] lane_mask;

    assign accept   = hsel && hready && (htrans == 2'b10 || htrans == 2'b11);
    // WAIT and ERR1 hold hreadyout low, so no address phase can complete in them
    assign capture  = accept && (state_q == IDLE || state_q == DATA || state_q == ERR2);
    assign addr_err = 32'(haddr[31:2]) >= MEM_DEPTH;
    assign xfer_err = (hsize > 3'b010)
                   || (hsize == 3'b001 && haddr[0])
                   || (hsize == 3'b010 && haddr[1:0] != 2'b00)
                   || addr_err;

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT:    state_d = DATA;
            ERR1:    state_d = ERR2;
            default: begin
                if (hready) begin
                    if (capture) state_d = xfer_err ? ERR1 : VALID_ST;
                    else         state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 2'b00;
            ready_q <= 1'b1;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                addr_q  <= haddr[AW+1:0];
                write_q <= hwrite;
                size_q  <= hsize[1:0];
            end
            ready_q <= !(state_d == WAIT || state_d == ERR1);
            resp_q  <= (state_d == ERR1 || state_d == ERR2);
        end
    end

    always_comb begin
        lane_mask = '0;
        case (size_q)
            2'b00:   lane_mask = 4'b0001 << addr_q[1:0];
            2'b01:   lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    end

    // Reset overrides the registered state so an in-flight access is dropped immediately
    assign data_ph        = (state_q == DATA) && !reset;
    assign mem_write_en   = data_ph && write_q;
    assign mem_read_en    = data_ph && !write_q;
    assign mem_mask       = data_ph ? lane_mask : '0;
    assign mem_address    = addr_q[AW+1:2];
    assign mem_write_data = mem_write_en ? hwdata : '0;
    assign hrdata         = mem_read_en ? mem_read_data : '0;
    assign hreadyout      = reset || ready_q;
    assign hresp          = !reset && resp_q;

endmodule
